mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
- Multi-cycle MIPS-subset core for the processor line; next generation after the single-cycle datapath.
- A hardwired FSM controller sequences one shared ALU and a single unified memory port over 3-5 cycles per instruction.
- Adds reset, a configurable reset vector, branches, jumps, stores, a retire strobe and a halt-on-illegal mode.
- Sits between the top level and a unified instruction/data memory with combinational read.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_ON_ILLEGAL, 1, 1: unknown opcode/funct enters HALT; 0: treated as NOP (retire, continue).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mem_addr  output  32  byte address to unified memory (PC in FETCH, ALUOut in MEMRD/MEMWR)
- mem_wdata  output  32  store data (register B)
- mem_we  output  1  memory write enable, asserted only in MEMWR
- mem_rdata  input  32  combinational read data for mem_addr, same cycle
- pc  output  32  current architectural PC
- retire  output  1  one-cycle pulse in the final cycle of each completed instruction
- halted  output  1  high while in HALT

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, PC=RESET_PC; IR, A, B, ALUOut and MDR cleared; all 32 registers cleared.
  - mem_we=0, retire=0, halted=0.
  - Reset mid-instruction aborts it; no register or memory write commits.
- Register file: 32x32; $0 reads 0 and ignores writes; writes occur on the clock edge ending the writeback state.
- States and transitions:
  - FETCH: mem_addr=PC; IR<=mem_rdata; PC<=PC+4 (wraps mod 2^32). Next DECODE.
  - DECODE: A<=R[rs]; B<=R[rt]; ALUOut<=PC+(signext(imm)<<2). Next by opcode:
    - 0x23 lw and 0x2B sw -> MEMADR
    - 0x00 R-type -> EXEC
    - 0x04 beq -> BRANCH
    - 0x08 addi -> ADDIEX
    - 0x02 j -> JUMP
    - anything else -> ILLEGAL
  - MEMADR: ALUOut<=A+signext(imm). Next MEMRD (lw) or MEMWR (sw).
  - MEMRD: mem_addr=ALUOut; MDR<=mem_rdata. Next MEMWB.
  - MEMWB: R[rt]<=MDR; retire. Next FETCH.
  - MEMWR: mem_addr=ALUOut, mem_wdata=B, mem_we=1; retire. Next FETCH.
  - EXEC: ALUOut<=A op B. Funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0). Other funct -> ILLEGAL. Otherwise next ALUWB.
  - ALUWB: R[rd]<=ALUOut; retire. Next FETCH.
  - BRANCH: if A==B then PC<=ALUOut; retire. Next FETCH.
  - ADDIEX: ALUOut<=A+signext(imm). Next ADDIWB.
  - ADDIWB: R[rt]<=ALUOut; retire. Next FETCH.
  - JUMP: PC<={PC[31:28], IR[25:0], 2'b00}; retire. Next FETCH.
  - ILLEGAL: HALT_ON_ILLEGAL=1 -> HALT with no retire. HALT_ON_ILLEGAL=0 -> retire, next FETCH.
  - HALT: absorbing until reset; halted=1; mem_we=0; PC frozen at illegal address+4.
- Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Arithmetic: 32-bit two's complement; overflow ignored (no trap); addresses not alignment-checked.
- mem_addr is don't-care outside FETCH/MEMRD/MEMWR, but mem_we must be 0 there.
- retire and mem_we are Moore outputs decoded from state.

Test Plan:
- Reset: rst_n low mid-lw, release -> pc=RESET_PC; no register write; mem_we=0; first mem_addr=RESET_PC.
- lw/sw: mem[0x40]=0xDEAD_BEEF; run "lw $2,0x40($0); sw $2,0x44($0)" -> $2=0xDEADBEEF after 5 cycles; then one cycle with mem_we=1, mem_addr=0x44, mem_wdata=0xDEADBEEF; retire pulses twice.
- R-type/addi: "addi $1,$0,-5; addi $2,$0,3; slt $3,$1,$2; sub $4,$2,$1" -> $1=0xFFFF_FFFB, $3=1, $4=8; writes to $0 leave $0=0.
- Branch/jump:
  - beq taken at 0x10, imm=-4 -> pc=0x04.
  - beq not taken -> pc=0x14.
  - j 0x0000_0100 at 0x20 -> pc=0x400; each takes 3 cycles.
- Illegal: opcode 0x3F at 0x08 with HALT_ON_ILLEGAL=1 -> halted=1, pc=0x0C held for 20 cycles, no retire. With HALT_ON_ILLEGAL=0 -> one retire, fetch continues at 0x0C.
- Wrap: RESET_PC=0xFFFF_FFFC, NOP (sll $0) -> next fetch address 0x0000_0000.

Source files
------------

// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data memory bus between the core and a combinational-read memory.
interface mips_multicycle_core_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: one shared ALU path, one unified memory port,
// hardwired FSM controller taking 3-5 cycles per instruction.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mips_multicycle_core_if.master        mem,
  output logic [31:0]                   pc_o,
  output logic                          retire_o,
  output logic                          halted_o
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
    StAluWb, StBranch, StAddiEx, StAddiWb, StJump, StIllegal, StHalt
  } state_e;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] aluout_q, aluout_d, mdr_q, mdr_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_o     = pc_q;

  // Architectural and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
    end
  end

  // Register file; $0 stays zero because writes to it are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Controller: next state, datapath register updates and Moore outputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    a_d           = a_q;
    b_d           = b_q;
    aluout_d      = aluout_q;
    mdr_d         = mdr_q;
    mem.mem_addr  = pc_q;
    mem.mem_wdata = b_q;
    mem.mem_we    = 1'b0;
    retire_o      = 1'b0;
    halted_o      = 1'b0;
    rf_we         = 1'b0;
    rf_waddr      = rt;
    rf_wdata      = aluout_q;

    unique case (state_q)
      StFetch: begin
        ir_d    = mem.mem_rdata;
        pc_d    = pc_q + 32'd4;
        state_d = StDecode;
      end
      StDecode: begin
        a_d      = rf_q[rs];
        b_d      = rf_q[rt];
        // Branch target precomputed here so BRANCH only needs the compare.
        aluout_d = pc_q + (imm_sext << 2);
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StIllegal;
        endcase
      end
      StMemAdr: begin
        aluout_d = a_q + imm_sext;
        state_d  = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem.mem_addr = aluout_q;
        mdr_d        = mem.mem_rdata;
        state_d      = StMemWb;
      end
      StMemWb: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        retire_o = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        mem.mem_addr = aluout_q;
        mem.mem_we   = 1'b1;
        retire_o     = 1'b1;
        state_d      = StFetch;
      end
      StExec: begin
        state_d = StAluWb;
        case (funct)
          6'h20:   aluout_d = a_q + b_q;
          6'h22:   aluout_d = a_q - b_q;
          6'h24:   aluout_d = a_q & b_q;
          6'h25:   aluout_d = a_q | b_q;
          6'h2A:   aluout_d = {31'd0, $signed(a_q) < $signed(b_q)};
          default: state_d  = StIllegal;
        endcase
      end
      StAluWb: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        retire_o = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        if (a_q == b_q) pc_d = aluout_q;
        retire_o = 1'b1;
        state_d  = StFetch;
      end
      StAddiEx: begin
        aluout_d = a_q + imm_sext;
        state_d  = StAddiWb;
      end
      StAddiWb: begin
        rf_we    = 1'b1;
        retire_o = 1'b1;
        state_d  = StFetch;
      end
      StJump: begin
        pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
        retire_o = 1'b1;
        state_d  = StFetch;
      end
      StIllegal: begin
        if (HALT_ON_ILLEGAL) begin
          state_d = StHalt;
        end else begin
          retire_o = 1'b1;
          state_d  = StFetch;
        end
      end
      StHalt: begin
        halted_o = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed programs plus random programs, each
// instruction checked against an instruction-level reference model.
module tb_mips_multicycle_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_core_if if_h ();
  mips_multicycle_core_if if_n ();

  logic [31:0] pc_h, pc_n;
  logic        ret_h, ret_n, hlt_h, hlt_n;

  // dut_h halts on illegal; dut_n treats illegal as NOP and starts at the top of memory.
  mips_multicycle_core #(.RESET_PC(32'h0000_0000), .HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .mem(if_h), .pc_o(pc_h), .retire_o(ret_h), .halted_o(hlt_h)
  );
  mips_multicycle_core #(.RESET_PC(32'hFFFF_FFFC), .HALT_ON_ILLEGAL(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .mem(if_n), .pc_o(pc_n), .retire_o(ret_n), .halted_o(hlt_n)
  );

  // 1 KiB memories, address bits above 9 alias.
  logic [31:0] mem_h [256];
  logic [31:0] mem_n [256];
  logic        ld_en = 1'b0, ld_sel = 1'b0;
  logic [7:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;

  assign if_h.mem_rdata = mem_h[if_h.mem_addr[9:2]];
  assign if_n.mem_rdata = mem_n[if_n.mem_addr[9:2]];

  always @(posedge clk) begin
    if (ld_en && !ld_sel) mem_h[ld_idx] <= ld_data;
    else if (if_h.mem_we) mem_h[if_h.mem_addr[9:2]] <= if_h.mem_wdata;
    if (ld_en && ld_sel) mem_n[ld_idx] <= ld_data;
    else if (if_n.mem_we) mem_n[if_n.mem_addr[9:2]] <= if_n.mem_wdata;
  end

  // Observation mux onto the DUT selected for the current test.
  logic        sel = 1'b0;
  logic [31:0] o_addr, o_wdata, o_pc;
  logic        o_we, o_ret, o_hlt;
  always_comb begin
    o_addr  = sel ? if_n.mem_addr  : if_h.mem_addr;
    o_wdata = sel ? if_n.mem_wdata : if_h.mem_wdata;
    o_we    = sel ? if_n.mem_we    : if_h.mem_we;
    o_pc    = sel ? pc_n  : pc_h;
    o_ret   = sel ? ret_n : ret_h;
    o_hlt   = sel ? hlt_n : hlt_h;
  end

  function automatic logic [31:0] dut_rf(input int i);
    return sel ? dut_n.rf_q[i] : dut_h.rf_q[i];
  endfunction

  function automatic logic [31:0] dut_mem(input int i);
    return sel ? mem_n[i] : mem_h[i];
  endfunction

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_rf [32];
  logic [31:0] m_mem [256];
  bit          m_halt_mode;

  localparam logic [31:0] Nop = 32'h2000_0000;  // addi $0,$0,0

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    logic [31:0] v;
    v = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    return v;
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    logic [31:0] v;
    v = {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    return v;
  endfunction

  // Executes one instruction; reports cycle count, store and halt.
  task automatic model_step(output int cyc, output bit st, output logic [31:0] st_addr,
                            output logic [31:0] st_data, output bit halt);
    logic [31:0] ir, pc4, sx, a, b, res, addr;
    int op, fn, rs, rt, rd;
    bit ill, wr;
    ir = m_mem[m_pc[9:2]];
    pc4 = m_pc + 32'd4;
    m_pc = pc4;
    op = int'(ir[31:26]); fn = int'(ir[5:0]);
    rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
    sx = {{16{ir[15]}}, ir[15:0]};
    a = m_rf[rs]; b = m_rf[rt];
    st = 0; st_addr = '0; st_data = '0; halt = 0; ill = 0; wr = 0; res = '0; cyc = 0;
    case (op)
      'h23: begin addr = a + sx; res = m_mem[addr[9:2]]; wr = 1; rd = rt; cyc = 5; end
      'h2B: begin
        st = 1; st_addr = a + sx; st_data = b; m_mem[st_addr[9:2]] = b; cyc = 4;
      end
      'h00: begin
        cyc = 4; wr = 1;
        case (fn)
          'h20: res = a + b;
          'h22: res = a - b;
          'h24: res = a & b;
          'h25: res = a | b;
          'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin ill = 1; wr = 0; end
        endcase
      end
      'h04: begin if (a == b) m_pc = pc4 + (sx << 2); cyc = 3; end
      'h08: begin res = a + sx; wr = 1; rd = rt; cyc = 4; end
      'h02: begin m_pc = {pc4[31:28], ir[25:0], 2'b00}; cyc = 3; end
      default: begin ill = 1; cyc = 3; end
    endcase
    if (wr && rd != 0) m_rf[rd] = res;
    if (ill && m_halt_mode) halt = 1;
  endtask

  task automatic load_mem(input bit s);
    ld_sel = s;
    ld_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_idx = i[7:0];
      ld_data = m_mem[i];
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  task automatic reset_and_load(input bit s);
    @(negedge clk);
    rst_n = 1'b0;
    sel = s;
    m_pc = s ? 32'hFFFF_FFFC : 32'h0;
    m_halt_mode = !s;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    load_mem(s);
    rst_n = 1'b1;
  endtask

  function automatic void fill_nops();
    for (int i = 0; i < 256; i++) m_mem[i] = Nop;
  endfunction

  // Steps n instructions on the DUT in lockstep with the model.
  task automatic run_steps(input int n);
    int cyc, c;
    bit st, seen_st, bad, halt;
    logic [31:0] sa, sd, fetch_pc;
    for (int k = 0; k < n; k++) begin
      fetch_pc = m_pc;
      model_step(cyc, st, sa, sd, halt);
      checks++;
      if (o_addr !== fetch_pc) begin
        errors++; $display("FAIL fetch_addr step %0d: got %h want %h", k, o_addr, fetch_pc);
      end
      if (halt) begin
        bad = 0;
        for (int j = 0; j < 23; j++) begin
          if (o_ret !== 1'b0 || o_we !== 1'b0) bad = 1;
          @(negedge clk);
        end
        checks++;
        if (bad) begin errors++; $display("FAIL halt_quiet: got retire/we activity want none"); end
        checks++;
        if (o_hlt !== 1'b1 || o_pc !== m_pc) begin
          errors++; $display("FAIL halt_state: got halted=%b pc=%h want 1 %h", o_hlt, o_pc, m_pc);
        end
        return;
      end
      c = 1; seen_st = 0;
      while (1) begin
        if (o_we === 1'b1) begin
          seen_st = 1;
          checks++;
          if (o_addr !== sa || o_wdata !== sd) begin
            errors++;
            $display("FAIL store step %0d: got %h/%h want %h/%h", k, o_addr, o_wdata, sa, sd);
          end
        end
        if (o_ret === 1'b1 || c >= 10) break;
        @(negedge clk);
        c++;
      end
      checks++;
      if (c != cyc || seen_st != st) begin
        errors++;
        $display("FAIL cycles step %0d: got %0d st=%b want %0d st=%b", k, c, seen_st, cyc, st);
      end
      @(negedge clk);
      checks++;
      if (o_pc !== m_pc) begin
        errors++; $display("FAIL next_pc step %0d: got %h want %h", k, o_pc, m_pc);
      end
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut_rf(i) !== m_rf[i]) begin
        errors++; $display("FAIL %s reg %0d: got %h want %h", tag, i, dut_rf(i), m_rf[i]);
      end
    end
  endtask

  task automatic check_reg_const(input int r, input logic [31:0] want);
    checks++;
    if (dut_rf(r) !== want) begin
      errors++; $display("FAIL reg_%0d: got %h want %h", r, dut_rf(r), want);
    end
  endtask

  task automatic test_reset();
    fill_nops();
    m_mem[0] = enc_i('h23, 0, 2, 'h40);
    m_mem[16] = 32'hDEAD_BEEF;
    reset_and_load(0);
    checks++;
    if (o_pc !== 32'h0 || o_we !== 1'b0 || o_ret !== 1'b0 || o_hlt !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got pc=%h we=%b ret=%b hlt=%b want 0 0 0 0",
                         o_pc, o_we, o_ret, o_hlt);
    end
    repeat (4) @(negedge clk);  // now in the lw writeback cycle
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_pc !== 32'h0 || o_we !== 1'b0 || dut_rf(2) !== 32'h0) begin
      errors++; $display("FAIL reset_mid_lw: got pc=%h we=%b r2=%h want 0 0 0",
                         o_pc, o_we, dut_rf(2));
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (o_addr !== 32'h0) begin
      errors++; $display("FAIL reset_first_fetch: got %h want 00000000", o_addr);
    end
  endtask

  task automatic test_lw_sw();
    fill_nops();
    m_mem[0] = enc_i('h23, 0, 2, 'h40);
    m_mem[1] = enc_i('h2B, 0, 2, 'h44);
    m_mem[16] = 32'hDEAD_BEEF;
    reset_and_load(0);
    run_steps(2);
    check_reg_const(2, 32'hDEAD_BEEF);
    checks++;
    if (dut_mem(17) !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_mem: got %h want deadbeef", dut_mem(17));
    end
  endtask

  task automatic test_alu();
    fill_nops();
    m_mem[0] = enc_i('h08, 0, 1, -5);
    m_mem[1] = enc_i('h08, 0, 2, 3);
    m_mem[2] = enc_r(1, 2, 3, 'h2A);
    m_mem[3] = enc_r(2, 1, 4, 'h22);
    m_mem[4] = enc_i('h08, 0, 0, 7);
    m_mem[5] = enc_r(1, 2, 0, 'h20);
    reset_and_load(0);
    run_steps(6);
    check_reg_const(1, 32'hFFFF_FFFB);
    check_reg_const(3, 32'd1);
    check_reg_const(4, 32'd8);
    check_reg_const(0, 32'd0);
  endtask

  task automatic test_branch_jump();
    for (int t = 0; t < 2; t++) begin
      fill_nops();
      m_mem[0] = enc_i('h08, 0, 1, 5);
      m_mem[1] = enc_i('h08, 0, 2, 5 + t);
      m_mem[4] = enc_i('h04, 1, 2, -4);
      reset_and_load(0);
      run_steps(5);
      checks++;
      if (o_pc !== ((t == 0) ? 32'h04 : 32'h14)) begin
        errors++; $display("FAIL beq_%0d: got %h want %h", t, o_pc, (t == 0) ? 32'h04 : 32'h14);
      end
    end
    fill_nops();
    m_mem[8] = {6'h02, 26'h100};
    reset_and_load(0);
    run_steps(9);
    checks++;
    if (o_pc !== 32'h400) begin
      errors++; $display("FAIL jump: got %h want 00000400", o_pc);
    end
  endtask

  task automatic test_illegal_halt();
    fill_nops();
    m_mem[2] = 32'hFC00_0000;
    reset_and_load(0);
    run_steps(3);
    checks++;
    if (o_pc !== 32'h0C || o_hlt !== 1'b1) begin
      errors++; $display("FAIL illegal_halt: got pc=%h hlt=%b want 0000000c 1", o_pc, o_hlt);
    end
  endtask

  task automatic test_wrap();
    fill_nops();
    m_mem[255] = 32'h0000_0000;  // sll $0,$0,0
    reset_and_load(1);
    checks++;
    if (o_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first_fetch: got %h want fffffffc", o_addr);
    end
    run_steps(1);
    checks++;
    if (o_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next_fetch: got %h want 00000000", o_addr);
    end
  endtask

  task automatic test_illegal_nop();
    fill_nops();
    m_mem[255] = 32'h0000_0000;
    m_mem[2] = 32'hFC00_0000;
    m_mem[3] = enc_i('h08, 0, 5, 9);
    reset_and_load(1);
    run_steps(5);
    check_reg_const(5, 32'd9);
    checks++;
    if (o_hlt !== 1'b0) begin
      errors++; $display("FAIL illegal_nop_halted: got %b want 0", o_hlt);
    end
  endtask

  task automatic test_random();
    int fns [5] = '{'h20, 'h22, 'h24, 'h25, 'h2A};
    for (int it = 0; it < 4; it++) begin
      fill_nops();
      for (int i = 192; i < 256; i++) m_mem[i] = $urandom;
      for (int i = 0; i < 128; i++) begin
        int rs, rt, rd;
        rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        case ($urandom_range(0, 5))
          0: m_mem[i] = enc_i('h08, rs, rt, int'($urandom_range(0, 65535)));
          1, 5: m_mem[i] = enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]);
          2: m_mem[i] = enc_i('h23, 0, rt, 'h300 + 4 * int'($urandom_range(0, 63)));
          3: m_mem[i] = enc_i('h2B, 0, rt, 'h300 + 4 * int'($urandom_range(0, 63)));
          default: m_mem[i] = enc_i('h04, rs, rt, int'($urandom_range(0, 3)));
        endcase
      end
      reset_and_load(0);
      run_steps(30);
      check_regs("random");
      for (int i = 192; i < 256; i++) begin
        checks++;
        if (dut_mem(i) !== m_mem[i]) begin
          errors++; $display("FAIL random mem %0d: got %h want %h", i, dut_mem(i), m_mem[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_sw();
    test_alu();
    test_branch_jump();
    test_illegal_halt();
    test_wrap();
    test_illegal_nop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
